// File: rtl/tdm_demux4b.sv
// ----------------------------------------------------------------------------
// tdm_demux4b
//   Receive side of a SLOTS-slot time-division serial link. Each accepted bit
//   is routed to the lane register of its slot, and complete frames are
//   reassembled into d. Frame alignment is taken from a sync marker that must
//   accompany every slot-0 bit; a missing or early marker is flagged on err.
//
// Ports
//   clk       : system clock, all state updates on the rising edge
//   rst       : synchronous active-high reset, wins over every other input
//   en        : bit-valid qualifier; y and sync are ignored while low
//   sync      : frame marker, high with en on the slot-0 bit of each frame
//   y         : serial TDM data bit
//   q         : per-lane latched outputs, q[slot] follows the bit of that slot
//   lane_stb  : one-hot strobe of the lane written by the last accepted bit
//   d         : last complete frame, d[k] = bit received in slot k
//   valid     : one-cycle pulse when d is loaded with a new frame
//   a         : slot index expected for the next accepted bit
//   locked    : frame alignment acquired
//   err       : one-cycle pulse on an alignment error
// ----------------------------------------------------------------------------
module tdm_demux4b #(
   parameter int SLOTS = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             y,
   output logic [SLOTS-1:0] q,
   output logic [SLOTS-1:0] lane_stb,
   output logic [SLOTS-1:0] d,
   output logic             valid,
   output logic [AW-1:0]    a,
   output logic             locked,
   output logic             err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_SLOT = AW'(SLOTS - 1);

   state_t           state_q;
   logic [SLOTS-1:0] lane_q;
   logic [SLOTS-1:0] stb_q;
   logic [SLOTS-1:0] frame_q;
   logic [SLOTS-1:0] shadow_q;   // bits of the frame currently being received
   logic [AW-1:0]    slot_q;
   logic             valid_q;
   logic             locked_q;
   logic             err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT;
         lane_q   <= '0;
         stb_q    <= '0;
         frame_q  <= '0;
         shadow_q <= '0;
         slot_q   <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // Strobes and pulses last exactly one cycle.
         stb_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (en) begin
            case (state_q)
               HUNT: begin
                  if (sync) begin
                     lane_q[0]   <= y;
                     shadow_q[0] <= y;
                     stb_q       <= SLOTS'(1);
                     slot_q      <= AW'(1);
                     locked_q    <= 1'b1;
                     state_q     <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (sync) begin
                     // A marker anywhere but slot 0 restarts the frame here:
                     // the partial frame is dropped and this bit becomes slot 0.
                     err_q       <= (slot_q != '0);
                     lane_q[0]   <= y;
                     shadow_q[0] <= y;
                     stb_q       <= SLOTS'(1);
                     slot_q      <= AW'(1);
                  end else if (slot_q == '0) begin
                     // Expected a marker; alignment is lost, bit is discarded.
                     err_q    <= 1'b1;
                     locked_q <= 1'b0;
                     slot_q   <= '0;
                     state_q  <= HUNT;
                  end else begin
                     lane_q[slot_q]   <= y;
                     shadow_q[slot_q] <= y;
                     stb_q            <= SLOTS'(1) << slot_q;
                     slot_q           <= slot_q + AW'(1);   // wraps to 0 after the last slot
                     if (slot_q == LAST_SLOT) begin
                        frame_q <= {y, shadow_q[SLOTS-2:0]};
                        valid_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q  <= HUNT;
                  locked_q <= 1'b0;
                  slot_q   <= '0;
               end
            endcase
         end
      end
   end

   assign q        = lane_q;
   assign lane_stb = stb_q;
   assign d        = frame_q;
   assign valid    = valid_q;
   assign a        = slot_q;
   assign locked   = locked_q;
   assign err      = err_q;

endmodule

// File: tb/tb_tdm_demux4b.sv
module tb_tdm_demux4b;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       sync = 1'b0;
   logic       y = 1'b0;
   logic [3:0] q;
   logic [3:0] lane_stb;
   logic [3:0] d;
   logic       valid;
   logic [1:0] a;
   logic       locked;
   logic       err;

   int n_assert = 0;
   int n_fail   = 0;

   tdm_demux4b #(.SLOTS(4), .AW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .y        (y),
      .q        (q),
      .lane_stb (lane_stb),
      .d        (d),
      .valid    (valid),
      .a        (a),
      .locked   (locked),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Reference model: the frame in progress is a queue of received bits;
   // its length is the next expected slot.
   bit         m_locked = 1'b0;
   bit         m_part[$];
   logic [3:0] m_q = '0;
   logic [3:0] m_d = '0;
   logic [3:0] m_stb = '0;
   logic       m_valid = 1'b0;
   logic       m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic s, input logic yy);
      m_stb   = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         m_part.delete();
         m_q = '0;
         m_d = '0;
      end else if (e) begin
         if (s) begin
            if (m_locked && m_part.size() != 0) m_err = 1'b1;
            m_locked = 1'b1;
            m_part.delete();
            m_part.push_back(yy);
            m_q[0] = yy;
            m_stb  = 4'b0001;
         end else if (m_locked) begin
            if (m_part.size() == 0) begin
               m_err    = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_q[m_part.size()] = yy;
               m_stb = 4'(1 << m_part.size());
               m_part.push_back(yy);
               if (m_part.size() == 4) begin
                  for (int i = 0; i < 4; i++) m_d[i] = m_part[i];
                  m_valid = 1'b1;
                  m_part.delete();
               end
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic s, input logic yy);
      rst = r; en = e; sync = s; y = yy;
      @(posedge clk);
      model(r, e, s, yy);
      #1;
      chk("q", q, m_q);
      chk("lane_stb", lane_stb, m_stb);
      chk("d", d, m_d);
      chk("valid", valid, m_valid);
      chk("a", a, m_locked ? m_part.size() : 0);
      chk("locked", locked, m_locked);
      chk("err", err, m_err);
   endtask

   initial begin
      bit         r_s;
      logic [1:0] nxt;

      // Reset held two cycles with all inputs active.
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
      chk("rst_all", {q, lane_stb, d, valid, a, locked, err}, 0);

      // Clean frame 1011 (slot bits 1,1,0,1).
      step(0, 1, 1, 1);
      chk("clean_locked", locked, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      chk("clean_d", d, 4'b1011);
      chk("clean_valid", valid, 1);
      chk("clean_stb", lane_stb, 4'b1000);

      // Back-to-back 0110 then 1001 with a two-cycle gap mid-frame.
      step(0, 1, 1, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      chk("b2b_d0", d, 4'b0110);
      step(0, 1, 1, 1);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      chk("gap_a", a, 2);
      step(0, 0, 1, 1);
      chk("gap_stb", lane_stb, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      chk("b2b_d1", d, 4'b1001);

      // Early sync after two bits.
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      chk("early_err", err, 1);
      chk("early_d", d, 4'b1001);
      chk("early_a", a, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 0);
      chk("early_d2", d, 4'b0101);

      // Missing sync after a full frame, then ignored bits, then relock.
      step(0, 1, 0, 1);
      chk("miss_err", err, 1);
      chk("miss_locked", locked, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      chk("hunt_stb", lane_stb, 0);
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      chk("relock_d", d, 4'b1100);

      // Reset mid-frame, then frame 1111.
      step(0, 1, 1, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(1, 1, 0, 1);
      chk("midrst_all", {q, lane_stb, d, valid, a, locked, err}, 0);
      for (int i = 0; i < 4; i++) step(0, 1, i == 0, 1);
      chk("ones_d", d, 4'b1111);

      // Randomized traffic, mostly well-formed with occasional faults.
      for (int i = 0; i < 600; i++) begin
         nxt = m_locked ? 2'(m_part.size()) : 2'd0;
         r_s = (nxt == 0);
         if ($urandom_range(0, 15) == 0) r_s = ~r_s;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, r_s, 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
